// File: rtl/exec_sequencer.sv
// ----------------------------------------------------------------------------
// exec_sequencer
//   Multi-cycle execution controller for the pico-MIPS datapath. It turns the
//   decoder's per-instruction flags into a PC advance enable and a gated
//   register-file write enable. It stalls for the iterative multiplier and
//   for valid/ready handshakes on the input switches and the output register.
//   Single-cycle instructions pass through with zero stall.
//
// Parameters
//   MULT_CYCLES : multiplier latency in cycles after mult_start (2..15)
//   CNT_W       : width of the multiply countdown counter (holds MULT_CYCLES-1)
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   mult       : decoder flag, current instruction is MULT
//   read_in    : decoder flag, current instruction is STIN
//   write_out  : decoder flag, current instruction is LOUT
//   reg_write  : decoder register-write request
//   in_valid   : external input data valid
//   out_ready  : external sink ready for output data
//   pc_en      : PC update enable (increment or branch)
//   reg_we     : gated register-file write enable
//   mult_start : one-cycle start pulse to the multiplier
//   in_ready   : processor is accepting input data
//   out_valid  : output data valid
//   state      : current FSM state, for debug
// ----------------------------------------------------------------------------
module exec_sequencer #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mult,
  input  logic       read_in,
  input  logic       write_out,
  input  logic       reg_write,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       pc_en,
  output logic       reg_we,
  output logic       mult_start,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] state
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] MULT_WAIT = 2'd1;
  localparam logic [1:0] IN_WAIT   = 2'd2;
  localparam logic [1:0] OUT_WAIT  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_en       = 1'b0;
    reg_we      = 1'b0;
    mult_start  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (r_state)
      RUN: begin
        // Flag priority on illegal multi-flag encodings: mult > read_in > write_out.
        if (mult) begin
          mult_start  = 1'b1;
          w_cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
          w_state_nxt = MULT_WAIT;
        end else if (read_in) begin
          in_ready = 1'b1;
          if (in_valid) begin
            pc_en  = 1'b1;
            reg_we = reg_write;
          end else begin
            w_state_nxt = IN_WAIT;
          end
        end else if (write_out) begin
          out_valid = 1'b1;
          if (out_ready) begin
            pc_en = 1'b1;
          end else begin
            w_state_nxt = OUT_WAIT;
          end
        end else begin
          pc_en  = 1'b1;
          reg_we = reg_write;
        end
      end

      MULT_WAIT: begin
        if (r_cnt == '0) begin
          pc_en       = 1'b1;
          reg_we      = reg_write;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      IN_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pc_en       = 1'b1;
          reg_we      = reg_write;
          w_state_nxt = RUN;
        end
      end

      OUT_WAIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pc_en       = 1'b1;
          w_state_nxt = RUN;
        end
      end

      default: begin
        w_state_nxt = RUN;
      end
    endcase

    // Outputs are Mealy; force them quiet while reset is held so an aborted
    // instruction never produces a write or a PC step.
    if (reset) begin
      pc_en      = 1'b0;
      reg_we     = 1'b0;
      mult_start = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle execution controller between the instruction decoder and the pico-MIPS datapath.
- Takes the decoder's per-instruction flags (mult, read_in, write_out, reg_write) and decides when the PC may advance and when the register file may write.
- Stalls for the iterative multiplier, and for valid/ready handshakes on the input switches and the output register.
- Single-cycle instructions pass through with zero stall.

Parameters:
- MULT_CYCLES, 4, multiplier latency in cycles after mult_start; legal range 2..15.
- CNT_W, 4, width of the internal multiply countdown counter; must hold MULT_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mult  input  1  decoder flag: current instruction is MULT.
- read_in  input  1  decoder flag: current instruction is STIN.
- write_out  input  1  decoder flag: current instruction is LOUT.
- reg_write  input  1  decoder register-write request.
- in_valid  input  1  external input data valid.
- out_ready  input  1  external sink ready for output data.
- pc_en  output  1  PC update enable (increment or branch).
- reg_we  output  1  gated register-file write enable.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- in_ready  output  1  processor is accepting input data.
- out_valid  output  1  output data valid.
- state  output  2  current FSM state, for debug.

Behaviour:
- FSM states and encodings: RUN=2'd0, MULT_WAIT=2'd1, IN_WAIT=2'd2, OUT_WAIT=2'd3.
- Registers: state and cnt (CNT_W bits) only. All outputs are combinational from state, cnt and inputs (Mealy).
- Reset: while reset=1, state=RUN, cnt=0, and every output is 0. Reset asserted mid-operation aborts the instruction: no reg_we and no pc_en are issued for it.
- Decoder flags are sampled only in RUN. In wait states they are ignored; the instruction is held because pc_en=0.
- Flag priority when more than one is set (illegal encoding): mult > read_in > write_out.
- RUN, no flag set: pc_en=1, reg_we=reg_write, remain in RUN.
- RUN with mult:
  - mult_start=1, pc_en=0, reg_we=0.
  - Load cnt <= MULT_CYCLES-1; next state MULT_WAIT.
- MULT_WAIT:
  - pc_en=0, reg_we=0, mult_start=0.
  - cnt decrements each cycle.
  - When cnt==0: pc_en=1, reg_we=reg_write, next state RUN.
  - Total MULT occupancy is MULT_CYCLES+1 cycles.
- RUN with read_in:
  - in_ready=1.
  - If in_valid=1 in the same cycle: pc_en=1, reg_we=reg_write, remain in RUN (zero stall).
  - Otherwise: pc_en=0, reg_we=0, next state IN_WAIT.
- IN_WAIT:
  - in_ready=1.
  - On in_valid=1: pc_en=1, reg_we=reg_write, next state RUN.
  - Otherwise hold with pc_en=0 and reg_we=0.
- RUN with write_out:
  - out_valid=1, reg_we=0.
  - If out_ready=1: pc_en=1, remain in RUN.
  - Otherwise: pc_en=0, next state OUT_WAIT.
- OUT_WAIT:
  - out_valid=1, reg_we=0.
  - On out_ready=1: pc_en=1, next state RUN. Otherwise hold.
- Handshake rules:
  - A transfer occurs on a cycle where valid and ready are both 1.
  - in_ready and out_valid deassert in the cycle after their transfer.
  - Exactly one pc_en pulse is issued per instruction.
- No combinational path from in_valid or out_ready back to the decoder flags.
- Unused state encodings are unreachable. If entered, the FSM returns to RUN next cycle with all outputs 0.

Test Plan:
- ADD (reg_write=1, no other flags) for 3 cycles -> pc_en=1 and reg_we=1 every cycle; state stays 0.
- MULT, MULT_CYCLES=4, flags asserted at cycle 0 -> mult_start=1 at cycle 0 only; pc_en=0 and reg_we=0 in cycles 0-3; pc_en=1 and reg_we=1 at cycle 4; state=0 at cycle 5.
- STIN with in_valid=1 already high -> in_ready=1, pc_en=1, reg_we=1 in the same cycle, with no stall. STIN with in_valid rising 3 cycles later -> state=2 for 3 cycles with pc_en=0; pc_en=1 and reg_we=1 in the in_valid cycle; then RUN.
- LOUT with out_ready=0 for 2 cycles, then 1 -> out_valid=1 for 3 cycles; reg_we=0 throughout; single pc_en pulse on cycle 3.
- reset pulsed while state=1, cnt=2 -> all outputs 0 immediately; after release state=0, cnt=0; no reg_we for the aborted MULT.
- mult=1 and read_in=1 simultaneously -> MULT path taken: mult_start=1, in_ready=0.
